// File: rtl/rr_arbiter8way16_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8way16_if
// Brief    : Request/data/handshake bundle between eight requesters, the
//            round-robin arbiter and the shared 16-bit consumer.
//            Optional `lock` vector present only when ARB_LOCK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface rr_arbiter8way16_if;
   logic [7:0]  req;
   logic [15:0] a, b, c, d, e, f, g, h;
   logic [7:0]  ack;
   logic [15:0] out;
   logic [2:0]  sel;
   logic        out_valid;
   logic        out_ready;
`ifdef ARB_LOCK_EN
   logic [7:0]  lock;
`endif

   // Arbiter side
   modport slave (
`ifdef ARB_LOCK_EN
      input  lock,
`endif
      input  req, a, b, c, d, e, f, g, h, out_ready,
      output ack, out, sel, out_valid
   );

   // Requesters plus consumer side
   modport master (
`ifdef ARB_LOCK_EN
      output lock,
`endif
      output req, a, b, c, d, e, f, g, h, out_ready,
      input  ack, out, sel, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter8way16.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8way16
// Brief    : 8-way x 16-bit round-robin arbiter feeding a one-entry output
//            buffer with valid/ready handshake. Define ARB_LOCK_EN to let the
//            last captured requester hold the grant via its lock bit.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter8way16 (
   input  wire logic         clk,
   input  wire logic         reset,
   rr_arbiter8way16_if.slave bus
);
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_out;
   logic [2:0]  r_sel;
   logic [2:0]  r_ptr;

   logic [15:0] w_data [8];
   logic        w_full;
   logic        w_can_take;
   logic        w_has_win;
   logic [2:0]  w_win;
   logic        w_capture;
   logic [7:0]  w_ack;

   assign w_data[0] = bus.a;
   assign w_data[1] = bus.b;
   assign w_data[2] = bus.c;
   assign w_data[3] = bus.d;
   assign w_data[4] = bus.e;
   assign w_data[5] = bus.f;
   assign w_data[6] = bus.g;
   assign w_data[7] = bus.h;

   assign w_full     = (r_state == ST_FULL);
   assign w_can_take = !w_full || bus.out_ready;

   // First requester at or after the rotate pointer, wrapping modulo 8.
   always_comb begin : arbitrate
      logic [2:0] idx;
      idx       = 3'd0;
      w_has_win = 1'b0;
      w_win     = r_ptr;
      for (int k = 0; k < 8; k++) begin
         idx = r_ptr + 3'(k);
         if (!w_has_win && bus.req[idx]) begin
            w_has_win = 1'b1;
            w_win     = idx;
         end
      end
`ifdef ARB_LOCK_EN
      if (bus.lock[r_sel] && bus.req[r_sel]) begin
         w_has_win = 1'b1;
         w_win     = r_sel;
      end
`endif
   end

   // Reset gates the grant so no requester sees an ack it will never get.
   always_comb begin : next_state
      w_state_nxt = r_state;
      w_capture   = !reset && w_can_take && w_has_win;
      w_ack       = w_capture ? (8'b0000_0001 << w_win) : 8'h00;
      case (r_state)
         ST_EMPTY: if (w_capture) w_state_nxt = ST_FULL;
         ST_FULL:  if (bus.out_ready && !w_capture) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_EMPTY;
         r_out   <= 16'h0000;
         r_sel   <= 3'd0;
         r_ptr   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_out <= w_data[w_win];
            r_sel <= w_win;
            r_ptr <= w_win + 3'd1;
         end
      end
   end

   assign bus.ack       = w_ack;
   assign bus.out       = r_out;
   assign bus.sel       = r_sel;
   assign bus.out_valid = w_full;
endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8way16.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter8way16
// Brief    : Self-checking bench for rr_arbiter8way16 against a queue-free
//            distance-based round-robin reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter8way16;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   rr_arbiter8way16_if bus ();

   rr_arbiter8way16 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic        m_full;
   int          m_ptr;
   logic [15:0] m_out;
   int          m_sel;

   function automatic logic [15:0] m_data(input int i);
      case (i)
         0: return bus.a;
         1: return bus.b;
         2: return bus.c;
         3: return bus.d;
         4: return bus.e;
         5: return bus.f;
         6: return bus.g;
         default: return bus.h;
      endcase
   endfunction

   // Winner = requesting index with the smallest forward distance from ptr.
   function automatic int m_winner();
      int best;
      int bestd;
      best  = -1;
      bestd = 8;
`ifdef ARB_LOCK_EN
      if (bus.lock[m_sel] && bus.req[m_sel]) return m_sel;
`endif
      for (int i = 0; i < 8; i++) begin
         if (bus.req[i] && (((i - m_ptr + 8) % 8) < bestd)) begin
            bestd = (i - m_ptr + 8) % 8;
            best  = i;
         end
      end
      return best;
   endfunction

   function automatic logic [7:0] m_ack();
      int w;
      w = m_winner();
      if (reset) return 8'h00;
      if ((!m_full || bus.out_ready) && w >= 0) return 8'(1 << w);
      return 8'h00;
   endfunction

   task automatic m_clear();
      m_full = 1'b0;
      m_ptr  = 0;
      m_out  = 16'h0000;
      m_sel  = 0;
   endtask

   // One clock: predict the capture from the inputs present before the edge.
   task automatic tick();
      int          w;
      logic        can;
      logic [15:0] dw;
      w   = m_winner();
      can = !m_full || bus.out_ready;
      dw  = (w >= 0) ? m_data(w) : 16'h0000;
      @(posedge clk);
      if (reset) m_clear();
      else if (can && w >= 0) begin
         m_out  = dw;
         m_sel  = w;
         m_ptr  = (w + 1) % 8;
         m_full = 1'b1;
      end else if (can) m_full = 1'b0;
      #1;
   endtask

   task automatic rand_data();
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      bus.c = 16'($urandom); bus.d = 16'($urandom);
      bus.e = 16'($urandom); bus.f = 16'($urandom);
      bus.g = 16'($urandom); bus.h = 16'($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_clear();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rand_data();
      bus.req       = 8'hFF;
      bus.out_ready = 1'($urandom);
      #3 reset = 1'b1;
      m_clear();
      #1;
      checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL rst_out actual=%h required=0000", bus.out); end
      checks++; if (bus.sel !== 3'd0) begin errors++; $display("FAIL rst_sel actual=%0d required=0", bus.sel); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid actual=%b required=0", bus.out_valid); end
      checks++; if (bus.ack !== 8'h00) begin errors++; $display("FAIL rst_ack actual=%h required=00", bus.ack); end
      tick();
      reset   = 1'b0;
      bus.req = 8'h00;
      #1;
      checks++; if (bus.ack !== 8'h00) begin errors++; $display("FAIL rel_ack actual=%h required=00", bus.ack); end
      tick();
      checks++; if (bus.out !== 16'h0000 || bus.sel !== 3'd0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL rel_hold actual=%h/%0d/%b required=0000/0/0", bus.out, bus.sel, bus.out_valid);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.req       = 8'b0000_1000;
      bus.d         = 16'b0001_0010_0011_0100;
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.ack !== 8'b0000_1000) begin errors++; $display("FAIL single_ack actual=%b required=00001000", bus.ack); end
      tick();
      bus.req = 8'h00;
      checks++; if (bus.out !== 16'h1234 || bus.sel !== 3'd3 || bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL single_out actual=%h/%0d/%b required=1234/3/1", bus.out, bus.sel, bus.out_valid);
      end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain actual=%b required=0", bus.out_valid); end
   endtask

   task automatic test_rotation();
      do_reset();
      bus.a = 16'h1111; bus.b = 16'h2222; bus.c = 16'h3333; bus.d = 16'h4444;
      bus.e = 16'h5555; bus.f = 16'h6666; bus.g = 16'h7777; bus.h = 16'h8888;
      bus.req       = 8'hFF;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         #1;
         checks++; if (bus.ack !== 8'(1 << (k % 8))) begin
            errors++; $display("FAIL rot_ack step=%0d actual=%b required=%b", k, bus.ack, 8'(1 << (k % 8)));
         end
         tick();
         checks++; if (bus.sel !== 3'(k % 8) || bus.out !== 16'(16'h1111 * ((k % 8) + 1)) || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL rot_out step=%0d actual=%h/%0d required=%h/%0d",
                               k, bus.out, bus.sel, 16'(16'h1111 * ((k % 8) + 1)), k % 8);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      rand_data();
      bus.a         = 16'hFFFF;
      bus.req       = 8'hFF;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         rand_data();
         #1;
         checks++; if (bus.ack !== 8'h00) begin errors++; $display("FAIL bp_ack cyc=%0d actual=%h required=00", k, bus.ack); end
         tick();
         checks++; if (bus.out !== 16'hFFFF || bus.sel !== 3'd0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold cyc=%0d actual=%h/%0d/%b required=ffff/0/1", k, bus.out, bus.sel, bus.out_valid);
         end
      end
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.ack !== 8'b0000_0010) begin errors++; $display("FAIL bp_resume_ack actual=%b required=00000010", bus.ack); end
      tick();
      checks++; if (bus.sel !== 3'd1 || bus.out !== bus.b) begin
         errors++; $display("FAIL bp_resume actual=%h/%0d required=%h/1", bus.out, bus.sel, bus.b);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      rand_data();
      bus.req       = 8'hFF;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      #2 reset = 1'b1;
      m_clear();
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000 || bus.ack !== 8'h00) begin
         errors++; $display("FAIL mid_rst actual=%b/%h/%h required=0/0000/00", bus.out_valid, bus.out, bus.ack);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++; if (bus.ack !== 8'h01) begin errors++; $display("FAIL mid_first_ack actual=%b required=00000001", bus.ack); end
      tick();
      checks++; if (bus.sel !== 3'd0 || bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL mid_first actual=%0d/%b required=0/1", bus.sel, bus.out_valid);
      end
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      do_reset();
      rand_data();
      bus.lock      = 8'h00;
      bus.req       = 8'hFF;
      bus.out_ready = 1'b1;
      repeat (6) tick();
      checks++; if (bus.sel !== 3'd5) begin errors++; $display("FAIL lock_pre actual=%0d required=5", bus.sel); end
      bus.lock = 8'b0010_0000;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (bus.sel !== 3'd5) begin errors++; $display("FAIL lock_hold cyc=%0d actual=%0d required=5", k, bus.sel); end
      end
      bus.lock = 8'h00;
      tick();
      checks++; if (bus.sel !== 3'd6) begin errors++; $display("FAIL lock_release actual=%0d required=6", bus.sel); end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         rand_data();
         bus.req       = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom & $urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
         bus.lock      = 8'($urandom & $urandom & $urandom);
`endif
         #1;
         checks++; if (bus.ack !== m_ack()) begin
            errors++; $display("FAIL rnd_ack cyc=%0d actual=%b required=%b", k, bus.ack, m_ack());
         end
         tick();
         checks++; if (bus.out_valid !== m_full || bus.out !== m_out || bus.sel !== 3'(m_sel)) begin
            errors++; $display("FAIL rnd_out cyc=%0d actual=%b/%h/%0d required=%b/%h/%0d",
                               k, bus.out_valid, bus.out, bus.sel, m_full, m_out, m_sel);
         end
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b0;
      bus.req       = 8'h00;
      bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
      bus.lock      = 8'h00;
`endif
      rand_data();
      m_clear();
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_reset_mid();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
